// File: rtl/vram_pkg.sv
// ============================================================================
// Module      : vram_pkg
// Description : Shared widths and requester identifiers for the VRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vram_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 2;

    // Requester identity, used both for the grant and the read-tag pipeline
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_SMP  = 2'd1,
        REQ_SCAN = 2'd2,
        REQ_HOST = 2'd3
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/vram_wr_fifo.sv
// ============================================================================
// Module      : vram_wr_fifo
// Description : Synchronous write FIFO with sticky drop/overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    input  logic                       ovf_clr,
    output logic [AW-1:0]              pop_addr,
    output logic [DW-1:0]              pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [AW-1:0]      r_addr_mem [DEPTH];
    logic [DW-1:0]      r_data_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign pop_addr  = r_addr_mem[r_rd_ptr];
    assign pop_data  = r_data_mem[r_rd_ptr];

    // A push into a full FIFO is dropped even if a pop happens in the same cycle
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_addr_mem[r_wr_ptr] <= push_addr;
            r_data_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set
            if (push && full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module      : vram_arbiter
// Description : Shares the single-port VRAM between sampler, scanout and host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW            = VRAM_AW,
    parameter int DW            = VRAM_DW,
    parameter int FIFO_DEPTH    = 4,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic          vramclk,
    input  logic          rst_n,
    input  logic          smp_we,
    input  logic [AW-1:0] smp_addr,
    input  logic [DW-1:0] smp_data,
    output logic          smp_overflow,
    input  logic          ovf_clr,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic          scan_gnt,
    output logic          scan_rvalid,
    output logic [DW-1:0] scan_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int c_WAIT_W = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0]  c_URGENT_CNT = c_CNT_W'(FIFO_DEPTH - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX   = c_WAIT_W'(HOST_MAX_WAIT);

    logic [AW-1:0]      w_fifo_addr;
    logic [DW-1:0]      w_fifo_data;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_fifo_urgent;
    logic               w_host_starving;
    logic               w_sel_read;
    req_id_t            w_sel;

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [AW-1:0]       r_mem_addr;
    logic [DW-1:0]       r_mem_wdata;
    req_id_t             r_tag1;
    req_id_t             r_tag2;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_wr_fifo (
        .clk       (vramclk),
        .rst_n     (rst_n),
        .push      (smp_we),
        .push_addr (smp_addr),
        .push_data (smp_data),
        .pop       (w_sel == REQ_SMP),
        .ovf_clr   (ovf_clr),
        .pop_addr  (w_fifo_addr),
        .pop_data  (w_fifo_data),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .overflow  (smp_overflow)
    );

    assign w_fifo_urgent   = w_fifo_full | (w_fifo_count >= c_URGENT_CNT);
    assign w_host_starving = host_req & (r_wait_cnt >= c_WAIT_MAX);

    // One winner per cycle; nothing is granted while reset is held
    always_comb begin
        w_sel = REQ_NONE;
        if (!rst_n) begin
            w_sel = REQ_NONE;
        end else if (w_fifo_urgent) begin
            w_sel = REQ_SMP;
        end else if (w_host_starving) begin
            w_sel = REQ_HOST;
        end else if (scan_req) begin
            w_sel = REQ_SCAN;
        end else if (!w_fifo_empty) begin
            w_sel = REQ_SMP;
        end else if (host_req) begin
            w_sel = REQ_HOST;
        end
    end

    assign scan_gnt   = (w_sel == REQ_SCAN);
    assign host_gnt   = (w_sel == REQ_HOST);
    assign w_sel_read = (w_sel == REQ_SCAN) || ((w_sel == REQ_HOST) && !host_we);

    always_ff @(posedge vramclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (host_gnt || !host_req) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt < c_WAIT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Registered RAM port; address and write data hold across idle cycles
    always_ff @(posedge vramclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tag1      <= REQ_NONE;
            r_tag2      <= REQ_NONE;
        end else begin
            r_mem_en <= (w_sel != REQ_NONE);
            case (w_sel)
                REQ_SMP: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_fifo_addr;
                    r_mem_wdata <= w_fifo_data;
                end
                REQ_SCAN: begin
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= scan_addr;
                end
                REQ_HOST: begin
                    r_mem_we   <= host_we;
                    r_mem_addr <= host_addr;
                    if (host_we) begin
                        r_mem_wdata <= host_wdata;
                    end
                end
                default: begin
                    r_mem_we <= 1'b0;
                end
            endcase
            r_tag1 <= w_sel_read ? w_sel : REQ_NONE;
            r_tag2 <= r_tag1;
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

    assign scan_rvalid = (r_tag2 == REQ_SCAN);
    assign host_rvalid = (r_tag2 == REQ_HOST);
    assign scan_rdata  = scan_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        smp_we = 1'b0;
    logic [15:0] smp_addr = '0;
    logic [1:0]  smp_data = '0;
    logic        smp_overflow;
    logic        ovf_clr = 1'b0;
    logic        scan_req = 1'b0;
    logic [15:0] scan_addr = '0;
    logic        scan_gnt;
    logic        scan_rvalid;
    logic [1:0]  scan_rdata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [1:0]  host_wdata = '0;
    logic        host_gnt;
    logic        host_rvalid;
    logic [1:0]  host_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata = '0;

    logic        f_push = 1'b0;
    logic [15:0] f_addr = '0;
    logic [1:0]  f_data = '0;
    logic        f_pop = 1'b0;
    logic        f_clr = 1'b0;
    logic [15:0] f_pop_addr;
    logic [1:0]  f_pop_data;
    logic [1:0]  f_count;
    logic        f_full;
    logic        f_empty;
    logic        f_ovf;

    int checks = 0;
    int failures = 0;

    logic [1:0]  ram [0:65535];
    logic [17:0] wlog [$];

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW(16), .DW(2), .FIFO_DEPTH(4), .HOST_MAX_WAIT(8)
    ) dut (
        .vramclk(clk), .rst_n(rst_n),
        .smp_we(smp_we), .smp_addr(smp_addr), .smp_data(smp_data),
        .smp_overflow(smp_overflow), .ovf_clr(ovf_clr),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
        .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    vram_wr_fifo #(.DEPTH(2), .AW(16), .DW(2)) u_fifo2 (
        .clk(clk), .rst_n(rst_n),
        .push(f_push), .push_addr(f_addr), .push_data(f_data),
        .pop(f_pop), .ovf_clr(f_clr),
        .pop_addr(f_pop_addr), .pop_data(f_pop_data),
        .count(f_count), .full(f_full), .empty(f_empty), .overflow(f_ovf)
    );

    // Single-port RAM model with one-cycle read latency, plus a write log
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wlog.push_back({mem_addr, mem_wdata});
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {3'b0, mem_en, mem_we, mem_addr, mem_wdata, scan_gnt, host_gnt,
                scan_rvalid, host_rvalid, scan_rdata, host_rdata, smp_overflow};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        scan;
        logic        host;
        logic        we;
        logic [15:0] addr;
        logic [1:0]  wdata;
        logic        exp_sg;
        logic        exp_hg;
        logic        exp_we;
        logic        exp_srv;
        logic        exp_hrv;
        logic [1:0]  exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_host;
        logic [15:0] addr;
        logic [1:0]  exp_rdata;
    } mix_t;

    // Runs host_req against continuous scanout; returns the grant offset
    task automatic run_starve(input string tag, output int gnt_at);
        gnt_at = -1;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            if (c == 0) begin
                scan_req  = 1'b1;
                scan_addr = 16'h2000;
                host_req  = 1'b1;
                host_we   = 1'b0;
                host_addr = 16'h0042;
            end
            @(negedge clk);
            if (host_gnt) begin
                gnt_at = c;
                break;
            end
        end
        next_cycle();
        host_req = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check({tag, "_host_rvalid"}, {host_rvalid, scan_rvalid}, 2'b10);
        check({tag, "_host_rdata"}, host_rdata, 2'b01);
    endtask

    vec_t vecs[8];
    mix_t mix[4];

    initial begin
        int          gnt_at;
        logic [6:0]  gnt_hist;
        logic        seen_rv;

        for (int i = 0; i < 65536; i++) ram[i] = 2'b00;
        ram[16'h1234] = 2'b10;
        ram[16'h0042] = 2'b01;
        ram[16'hffff] = 2'b11;

        //            scan  host  we    addr      wd     sg    hg    mwe   srv   hrv   rdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0042, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0100, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'hffff, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0055, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0055, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};

        mix[0] = '{1'b0, 16'h1234, 2'b10};
        mix[1] = '{1'b1, 16'h0042, 2'b01};
        mix[2] = '{1'b0, 16'hffff, 2'b11};
        mix[3] = '{1'b1, 16'h0100, 2'b11};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outputs(), 32'h0);
        check("fifo2_reset", {f_count, f_full, f_empty, f_ovf}, 5'b00010);
        next_cycle();
        rst_n = 1'b1;

        // Single transactions from the vector table
        for (int v = 0; v < 8; v++) begin
            next_cycle();
            scan_req   = vecs[v].scan;
            scan_addr  = vecs[v].addr;
            host_req   = vecs[v].host;
            host_we    = vecs[v].we;
            host_addr  = vecs[v].addr;
            host_wdata = vecs[v].wdata;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", v), {scan_gnt, host_gnt}, {vecs[v].exp_sg, vecs[v].exp_hg});
            next_cycle();
            scan_req = 1'b0;
            host_req = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_port", v), {mem_en, mem_we, mem_addr}, {1'b1, vecs[v].exp_we, vecs[v].addr});
            if (vecs[v].exp_we) begin
                check($sformatf("vec%0d_wdata", v), mem_wdata, vecs[v].wdata);
            end
            next_cycle();
            @(negedge clk);
            check($sformatf("vec%0d_rvalid", v), {scan_rvalid, host_rvalid}, {vecs[v].exp_srv, vecs[v].exp_hrv});
            check($sformatf("vec%0d_rdata", v), vecs[v].exp_srv ? scan_rdata : host_rdata, vecs[v].exp_rdata);
        end

        // Sampler burst of 5 against continuous scanout
        next_cycle();
        wlog.delete();
        gnt_hist = '0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            scan_req  = 1'b1;
            scan_addr = 16'h2000;
            smp_we    = (c < 5);
            smp_addr  = 16'h3000 + 16'(c);
            smp_data  = 2'(c + 1);
            @(negedge clk);
            gnt_hist[c] = scan_gnt;
        end
        next_cycle();
        scan_req = 1'b0;
        smp_we   = 1'b0;
        repeat (5) next_cycle();
        check("burst_scan_gnt_pattern", gnt_hist, 7'b1000111);
        check("burst_overflow", smp_overflow, 1'b0);
        check("burst_write_count", wlog.size(), 5);
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            check($sformatf("burst_write%0d", i), wlog[i], {16'h3000 + 16'(i), 2'(i + 1)});
        end

        // Host starvation: granted exactly 8 cycles in, then counter restarts
        run_starve("starve1", gnt_at);
        check("starve1_latency", gnt_at, 8);
        run_starve("starve2", gnt_at);
        check("starve2_latency", gnt_at, 8);
        next_cycle();
        scan_req = 1'b0;
        repeat (3) next_cycle();

        // Alternating scan/host reads: rvalid routed to the issuer at +2
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            scan_req = 1'b0;
            host_req = 1'b0;
            if (c < 4) begin
                scan_req  = ~mix[c].is_host;
                scan_addr = mix[c].addr;
                host_req  = mix[c].is_host;
                host_we   = 1'b0;
                host_addr = mix[c].addr;
            end
            @(negedge clk);
            if (c < 4) begin
                check($sformatf("mix%0d_gnt", c), {scan_gnt, host_gnt}, {~mix[c].is_host, mix[c].is_host});
            end
            if (c >= 2) begin
                check($sformatf("mix%0d_rvalid", c - 2), {scan_rvalid, host_rvalid},
                      {~mix[c-2].is_host, mix[c-2].is_host});
                check($sformatf("mix%0d_rdata", c - 2), mix[c-2].is_host ? host_rdata : scan_rdata,
                      mix[c-2].exp_rdata);
            end
        end

        // Reset in the cycle after a scan grant drops the read
        next_cycle();
        scan_req  = 1'b1;
        scan_addr = 16'h1234;
        @(negedge clk);
        check("rstread_gnt", scan_gnt, 1'b1);
        next_cycle();
        rst_n    = 1'b0;
        scan_req = 1'b0;
        #1;
        check("rstread_outputs", all_outputs(), 32'h0);
        seen_rv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                next_cycle();
                rst_n = 1'b1;
            end
            @(negedge clk);
            seen_rv |= scan_rvalid;
        end
        check("rstread_no_rvalid", seen_rv, 1'b0);

        // Standalone depth-2 FIFO overflow behaviour
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            f_push = 1'b1;
            f_addr = 16'h4000 + 16'(c);
            f_data = 2'(c);
            @(negedge clk);
            check($sformatf("fifo2_ovf_c%0d", c), f_ovf, (c >= 3));
        end
        next_cycle();
        f_push = 1'b0;
        f_clr  = 1'b1;
        @(negedge clk);
        check("fifo2_ovf_before_clr", f_ovf, 1'b1);
        next_cycle();
        f_clr = 1'b0;
        @(negedge clk);
        check("fifo2_ovf_cleared", f_ovf, 1'b0);
        check("fifo2_full", {f_count, f_full, f_empty}, 4'b1010);
        next_cycle();
        f_push = 1'b1;
        f_clr  = 1'b1;
        next_cycle();
        f_push = 1'b0;
        f_clr  = 1'b0;
        @(negedge clk);
        check("fifo2_set_wins", f_ovf, 1'b1);
        next_cycle();
        f_pop = 1'b1;
        @(negedge clk);
        check("fifo2_head", {f_pop_addr, f_pop_data}, {16'h4000, 2'd0});
        next_cycle();
        f_pop = 1'b0;
        @(negedge clk);
        check("fifo2_after_pop", {f_count, f_pop_addr, f_pop_data}, {2'd1, 16'h4001, 2'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
